// File: rtl/clock_pkg.sv
// Shared clock-datapath definitions: mode encodings, BCD field limits and BCD increment.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_e;

    localparam logic [7:0] BCD_MAX_SEC_MIN = 8'h59;
    localparam logic [7:0] BCD_MAX_HOUR    = 8'h23;

    // Two-digit BCD +1; the caller handles the field modulus before calling.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX; wrap flags an increment taken at MAX.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX = BCD_MAX_SEC_MIN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] reset_val,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       wrap
);

    logic [7:0] value_q, value_d;

    assign wrap  = inc & (value_q == MAX);
    assign value = value_q;

    // NOTE: value_d gets a default before any branch so the block can never infer a latch.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 8'h00;
        end else if (inc) begin
            value_d = wrap ? 8'h00 : bcd_inc(value_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= reset_val;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/timekeeper_ctrl.sv
// Time-of-day controller: BCD hh:mm:ss driven by the 1 Hz tick, with a set-mode FSM,
// a once-per-minute pulse and display blink enables.
module timekeeper_ctrl
    import clock_pkg::*;
#(
    parameter logic [7:0] RESET_HOUR = 8'h00,
    parameter logic [7:0] RESET_MIN  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       blink_hour,
    output logic       blink_min,
    output logic       min_tick
);

    mode_e mode_q, mode_d;
    logic  phase_q, phase_d;
    logic  blink_hour_q, blink_min_q, min_tick_q;
    logic  sec_clr;
    logic  sec_inc, min_inc, hour_inc;
    logic  sec_wrap, min_wrap, hour_wrap_unused;
    logic  in_run, in_set_hour, in_set_min;

    assign in_run      = (mode_q == MODE_RUN);
    assign in_set_hour = (mode_q == MODE_SET_HOUR);
    assign in_set_min  = (mode_q == MODE_SET_MIN);

    // A mode press in a set state swallows a coincident increment.
    assign sec_inc  = in_run & sec_tick;
    assign min_inc  = (in_run & sec_wrap) | (in_set_min & btn_inc & ~btn_mode);
    assign hour_inc = (in_run & min_wrap) | (in_set_hour & btn_inc & ~btn_mode);

    bcd_mod_counter #(.MAX(BCD_MAX_SEC_MIN)) u_sec (
        .clk(clk), .rst(rst), .reset_val(8'h00), .inc(sec_inc), .clr(sec_clr),
        .value(sec_bcd), .wrap(sec_wrap)
    );

    bcd_mod_counter #(.MAX(BCD_MAX_SEC_MIN)) u_min (
        .clk(clk), .rst(rst), .reset_val(RESET_MIN), .inc(min_inc), .clr(1'b0),
        .value(min_bcd), .wrap(min_wrap)
    );

    bcd_mod_counter #(.MAX(BCD_MAX_HOUR)) u_hour (
        .clk(clk), .rst(rst), .reset_val(RESET_HOUR), .inc(hour_inc), .clr(1'b0),
        .value(hour_bcd), .wrap(hour_wrap_unused)
    );

    always_comb begin
        mode_d  = mode_q;
        phase_d = phase_q;
        sec_clr = 1'b0;
        case (mode_q)
            MODE_RUN: begin
                phase_d = 1'b0;
                if (btn_mode) mode_d = MODE_SET_HOUR;
            end
            MODE_SET_HOUR: begin
                if (btn_mode) begin
                    mode_d  = MODE_SET_MIN;
                    phase_d = 1'b0;
                end else if (sec_tick) begin
                    phase_d = ~phase_q;
                end
            end
            MODE_SET_MIN: begin
                if (btn_mode) begin
                    mode_d  = MODE_RUN;
                    phase_d = 1'b0;
                    sec_clr = 1'b1;
                end else if (sec_tick) begin
                    phase_d = ~phase_q;
                end
            end
            default: begin
                mode_d  = MODE_RUN;
                phase_d = 1'b0;
            end
        endcase
    end

    // Blink enables are registered from next-state so they line up with the new mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= MODE_RUN;
            phase_q      <= 1'b0;
            blink_hour_q <= 1'b0;
            blink_min_q  <= 1'b0;
            min_tick_q   <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            phase_q      <= phase_d;
            blink_hour_q <= (mode_d == MODE_SET_HOUR) & phase_d;
            blink_min_q  <= (mode_d == MODE_SET_MIN) & phase_d;
            min_tick_q   <= in_run & sec_wrap;
        end
    end

    assign mode       = mode_q;
    assign blink_hour = blink_hour_q;
    assign blink_min  = blink_min_q;
    assign min_tick   = min_tick_q;

endmodule

// File: tb/tb_timekeeper_ctrl.sv
// Directed bench for timekeeper_ctrl: a vector table for single-cycle behaviour plus
// hand-written sequences for wrap, preload, rollover and asynchronous reset.
module tb_timekeeper_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sec_tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [1:0] mode;
    logic       blink_hour, blink_min, min_tick;

    int n_checks = 0;
    int n_pass   = 0;
    int tick_count;

    timekeeper_ctrl dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .mode(mode),
        .blink_hour(blink_hour), .blink_min(blink_min), .min_tick(min_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       t, m, i;
        logic [7:0] h, mi, s;
        logic [1:0] md;
        logic       bh, bm, mt;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic check_all(input string name, input logic [7:0] h, input logic [7:0] mi,
                             input logic [7:0] s, input logic [1:0] md, input logic bh,
                             input logic bm, input logic mt);
        check({name, ".hour"}, hour_bcd, h);
        check({name, ".min"}, min_bcd, mi);
        check({name, ".sec"}, sec_bcd, s);
        check({name, ".mode"}, {6'd0, mode}, {6'd0, md});
        check({name, ".blink_hour"}, {7'd0, blink_hour}, {7'd0, bh});
        check({name, ".blink_min"}, {7'd0, blink_min}, {7'd0, bm});
        check({name, ".min_tick"}, {7'd0, min_tick}, {7'd0, mt});
    endtask

    // Inputs are held for exactly one edge, then sampled 1 time unit after it.
    task automatic pulse(input logic t, input logic m, input logic i);
        sec_tick = t;
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
        sec_tick = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic repeat_pulse(input int n, input logic t, input logic i);
        for (int k = 0; k < n; k++) pulse(t, 1'b0, i);
    endtask

    initial begin
        //            t     m     i     hour   min    sec    mode   bh    bm    mt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h02, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 8'h02, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h02, 8'h00, 8'h02, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h02, 8'h00, 8'h02, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 8'h02, 2'd2, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h02, 8'h01, 8'h02, 2'd2, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h02, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h02, 8'h01, 8'h01, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h02, 8'h01, 8'h01, 2'd0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_all("reset_held", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        pulse(1'b0, 1'b0, 1'b0);
        check_all("reset_release", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);

        for (int v = 0; v < 12; v++) begin
            pulse(vecs[v].t, vecs[v].m, vecs[v].i);
            check_all($sformatf("vec%0d", v), vecs[v].h, vecs[v].mi, vecs[v].s, vecs[v].md,
                      vecs[v].bh, vecs[v].bm, vecs[v].mt);
        end

        // Hour field wraps 23 -> 00 in SET_HOUR; 25 presses from 02 land on 03.
        pulse(1'b0, 1'b1, 1'b0);
        repeat_pulse(21, 1'b0, 1'b1);
        check("set_hour_23", hour_bcd, 8'h23);
        pulse(1'b0, 1'b0, 1'b1);
        check("set_hour_wrap", hour_bcd, 8'h00);
        repeat_pulse(3, 1'b0, 1'b1);
        check_all("set_hour_25", 8'h03, 8'h01, 8'h01, 2'd1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check("set_hour_sec_frozen", sec_bcd, 8'h01);

        // Minute field wraps 59 -> 00 without carrying into hours.
        pulse(1'b0, 1'b1, 1'b0);
        repeat_pulse(57, 1'b0, 1'b1);
        check("set_min_58", min_bcd, 8'h58);
        repeat_pulse(2, 1'b0, 1'b1);
        check("set_min_wrap", min_bcd, 8'h00);
        pulse(1'b0, 1'b0, 1'b1);
        check_all("set_min_01", 8'h03, 8'h01, 8'h01, 2'd2, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check_all("exit_set_min", 8'h03, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);

        // Preload 23:59, tick up to 23:59:58, then roll the whole day over.
        pulse(1'b0, 1'b1, 1'b0);
        repeat_pulse(20, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        repeat_pulse(58, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        check_all("preload", 8'h23, 8'h59, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        tick_count = 0;
        for (int k = 0; k < 58; k++) begin
            pulse(1'b1, 1'b0, 1'b0);
            if (min_tick) tick_count++;
        end
        check("tick_to_58", sec_bcd, 8'h58);
        pulse(1'b1, 1'b0, 1'b0);
        if (min_tick) tick_count++;
        check_all("at_235959", 8'h23, 8'h59, 8'h59, 2'd0, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        if (min_tick) tick_count++;
        check_all("rollover", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b0);
        if (min_tick) tick_count++;
        check("min_tick_one_cycle", {7'd0, min_tick}, 8'h00);
        check("min_tick_count", tick_count[7:0], 8'd1);

        // Reach 12:34:56 and reset asynchronously between edges.
        pulse(1'b0, 1'b1, 1'b0);
        repeat_pulse(12, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        repeat_pulse(34, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        repeat_pulse(56, 1'b1, 1'b0);
        check_all("at_123456", 8'h12, 8'h34, 8'h56, 2'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        check_all("after_reset_tick", 8'h00, 8'h00, 8'h01, 2'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
